mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store unit; consumes the EX/MEM fields produced by execute and emits MEM/WB fields.
//  Drives a req/ack data-memory port, with byte-lane steering for SB/SH/SW.
//  Performs LB/LH/LW/LBU/LHU extraction and extension.
//  Stalls upstream stages while an access is outstanding.
//  Flags misaligned accesses and memory timeouts.
// PARAMETERS
//  DATA_W    32  data/ALU result width
//  ADDR_W    9   dm_addr width (word address)
//  MAX_WAIT  15  ACCESS cycles without dm_ack before abort (>=1)
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-high
//  ex_valid       in   1       EX/MEM holds a real instruction (0 = bubble)
//  memread        in   1       load
//  memwrite       in   1       store
//  regwrite       in   1       instruction writes rd
//  memtoreg       in   2       WB source select, passed through
//  rd             in   5       destination register
//  alu_result     in   DATA_W  byte address / ALU result
//  memwritedata   in   DATA_W  store data (rs2)
//  pcplus4        in   DATA_W  passed through
//  readdatasel    in   3       000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU
//  writedatasel   in   2       00 SB, 01 SH, 10 SW
//  err_clr        in   1       clears sticky error flags
//  dm_req         out  1       memory request
//  dm_we          out  1       1 = write
//  dm_addr        out  ADDR_W  alu_result[ADDR_W+1:2]
//  dm_be          out  4       byte enables
//  dm_wdata       out  DATA_W  lane-replicated store data
//  dm_ack         in   1       access complete; dm_rdata valid same cycle
//  dm_rdata       in   DATA_W  read word
//  mem_stall      out  1       hold EX/MEM and earlier stages
//  wb_valid, wb_regwrite, wb_memtoreg, wb_rd, wb_aluresult, wb_pcplus4, wb_readdata  out  registered MEM/WB fields
//  misalign_err   out  1       sticky
//  timeout_err    out  1       sticky
// BEHAVIOUR
//  Reset (async)
//   - State goes to IDLE and the wait counter to 0.
//   - All outputs go to 0, including dm_req immediately, even mid-access.
//  Misalignment
//   - LH/LHU/SH with addr[0]=1 is misaligned.
//   - LW/SW with addr[1:0]!=0 is misaligned.
//  IDLE state
//   - Non-memory ex_valid: WB fields registered next edge, wb_valid=1 (latency 1), mem_stall=0.
//   - Misaligned memop: no dm_req; wb_valid=1 with wb_regwrite=0 next edge; misalign_err set.
//   - Aligned memop: mem_stall=1 combinationally; op is latched; next state ACCESS.
//   - Bubble: wb_valid=0.
//  ACCESS state
//   - dm_req=1; dm_we/addr/be/wdata come from the latched op; inputs are ignored.
//   - mem_stall = !dm_ack.
//   - On dm_ack: WB fields registered from the latched op, wb_valid=1, next state IDLE.
//     Upstream advances on that same edge, so no instruction is issued twice.
//   - Else, counter increments. When counter==MAX_WAIT-1 without ack:
//     - dm_req drops next edge;
//     - wb_valid=1 with wb_regwrite=0;
//     - timeout_err set;
//     - state returns to IDLE.
//   - wb_valid=0 in every ACCESS cycle without completion.
//  dm_ack outside ACCESS is ignored.
//  Store lanes
//   - SB: be = 1<<a[1:0], wdata = {4{wd[7:0]}}.
//   - SH: be = a[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}.
//   - SW: be = 1111, wdata = wd.
//   - For loads, be=1111 and dm_we=0.
//  Load extraction (lane from latched addr[1:0])
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
//   - wb_readdata is registered with the WB fields.
//  Sticky errors
//   - Cleared by err_clr at the next edge.
//   - If set and clear coincide, set wins.
// TESTING
//  1. ALU op, ex_valid=1, rd=5, alu_result=0x1234
//     -> next cycle wb_valid=1, wb_aluresult=0x1234, mem_stall never high.
//  2. LB at addr 0x07, dm_rdata=0x80FF_FF00, ack after 3 cycles
//     -> dm_addr=1, be=1111, mem_stall high 3 cycles, wb_readdata=0xFFFFFF80.
//  3. SH at addr 0x06, wd=0x0000BEEF, ack same cycle as first req
//     -> dm_we=1, be=1100, dm_wdata=0xBEEFBEEF, single stall cycle.
//  4. LW at addr 0x02
//     -> no dm_req, misalign_err=1, wb_regwrite=0, then err_clr clears the flag.
//  5. LHU with no ack
//     -> dm_req high exactly MAX_WAIT cycles, timeout_err=1, wb_regwrite=0, stall released.
//  6. Reset asserted mid-ACCESS
//     -> dm_req/mem_stall drop without waiting for a clock; after release, state is IDLE with no spurious wb_valid.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit.
// Takes the EX/MEM fields from execute, runs a req/ack data-memory access
// with byte-lane steering, extracts and extends load data, and registers the
// MEM/WB fields. Upstream is stalled while an access is outstanding.
// Misaligned accesses and memories that never acknowledge are flagged in
// sticky error bits.
// The store lane steering assumes a 32-bit data word (DATA_W = 32).
module mem_access_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              regwrite,
  input  logic [1:0]        memtoreg,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] memwritedata,
  input  logic [DATA_W-1:0] pcplus4,
  input  logic [2:0]        readdatasel,
  input  logic [1:0]        writedatasel,
  input  logic              err_clr,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [1:0]        wb_memtoreg,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_aluresult,
  output logic [DATA_W-1:0] wb_pcplus4,
  output logic [DATA_W-1:0] wb_readdata,
  output logic              misalign_err,
  output logic              timeout_err
);

  // Wait counter only has to reach MAX_WAIT-1.
  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  // Load size encodings on readdatasel.
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // Store size encodings on writedatasel.
  localparam logic [1:0] ST_B = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Memory operation captured when it leaves IDLE; drives the port while
  // upstream is stalled and supplies the WB fields on completion.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        lane;
    logic [2:0]        rsel;
    logic              regwrite;
    logic [1:0]        memtoreg;
    logic [4:0]        rd;
    logic [DATA_W-1:0] aluresult;
    logic [DATA_W-1:0] pcplus4;
  } op_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [1:0]        memtoreg;
    logic [4:0]        rd;
    logic [DATA_W-1:0] aluresult;
    logic [DATA_W-1:0] pcplus4;
    logic [DATA_W-1:0] readdata;
  } wb_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_t               op_q, op_d;
  wb_t               wb_q, wb_d;
  logic              misalign_err_q, misalign_err_d;
  logic              timeout_err_q, timeout_err_d;

  logic              is_memop;
  logic              misaligned;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;
  logic              misalign_set;
  logic              timeout_set;
  logic              stall_c;

  // Decode the incoming op: alignment check and store lane steering.
  always_comb begin
    // NOTE: every signal gets a default before the case logic so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    is_memop   = ex_valid && (memread || memwrite);
    misaligned = 1'b0;
    st_be      = 4'b1111;
    st_wdata   = '0;
    if (memwrite) begin
      case (writedatasel)
        ST_B: begin
          st_be    = 4'b0001 << alu_result[1:0];
          st_wdata = {4{memwritedata[7:0]}};
        end
        ST_H: begin
          st_be      = alu_result[1] ? 4'b1100 : 4'b0011;
          st_wdata   = {2{memwritedata[15:0]}};
          misaligned = alu_result[0];
        end
        default: begin
          st_wdata   = memwritedata;
          misaligned = |alu_result[1:0];
        end
      endcase
    end else begin
      case (readdatasel)
        LD_B, LD_BU: misaligned = 1'b0;
        LD_H, LD_HU: misaligned = alu_result[0];
        default:     misaligned = |alu_result[1:0];
      endcase
    end
  end

  // Pick the addressed lane of the returned word and extend it.
  always_comb begin
    ld_byte = dm_rdata[{op_q.lane, 3'b000} +: 8];
    ld_half = op_q.lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op_q.rsel)
      LD_B:    ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      LD_H:    ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      LD_BU:   ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      LD_HU:   ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      LD_W:    ld_data = dm_rdata;
      default: ld_data = dm_rdata;
    endcase
  end

  // Next-state, op capture, WB field and error-flag logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    wb_d         = wb_q;
    wb_d.valid   = 1'b0;
    misalign_set = 1'b0;
    timeout_set  = 1'b0;
    stall_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_memop || misaligned) begin
            // ALU op, or a memop rejected without touching memory.
            wb_d.valid     = 1'b1;
            wb_d.regwrite  = regwrite && !is_memop;
            wb_d.memtoreg  = memtoreg;
            wb_d.rd        = rd;
            wb_d.aluresult = alu_result;
            wb_d.pcplus4   = pcplus4;
            wb_d.readdata  = '0;
            misalign_set   = is_memop;
          end else begin
            stall_c        = 1'b1;
            op_d.we        = memwrite;
            op_d.addr      = alu_result[ADDR_W+1:2];
            op_d.be        = memwrite ? st_be : 4'b1111;
            op_d.wdata     = st_wdata;
            op_d.lane      = alu_result[1:0];
            op_d.rsel      = readdatasel;
            op_d.regwrite  = regwrite;
            op_d.memtoreg  = memtoreg;
            op_d.rd        = rd;
            op_d.aluresult = alu_result;
            op_d.pcplus4   = pcplus4;
            cnt_d          = '0;
            state_d        = ACCESS;
          end
        end
      end

      ACCESS: begin
        // Upstream advances on the ack edge, so the op is never re-issued.
        stall_c        = !dm_ack;
        wb_d.memtoreg  = op_q.memtoreg;
        wb_d.rd        = op_q.rd;
        wb_d.aluresult = op_q.aluresult;
        wb_d.pcplus4   = op_q.pcplus4;
        if (dm_ack) begin
          wb_d.valid    = 1'b1;
          wb_d.regwrite = op_q.regwrite;
          wb_d.readdata = op_q.we ? '0 : ld_data;
          cnt_d         = '0;
          state_d       = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the access: retire the op without a register write.
          wb_d.valid    = 1'b1;
          wb_d.regwrite = 1'b0;
          wb_d.readdata = '0;
          timeout_set   = 1'b1;
          cnt_d         = '0;
          state_d       = IDLE;
        end else begin
          wb_d          = wb_q;
          wb_d.valid    = 1'b0;
          cnt_d         = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // A new error in the same cycle as a clear still sets the flag.
    misalign_err_d = misalign_set || (misalign_err_q && !err_clr);
    timeout_err_d  = timeout_set  || (timeout_err_q  && !err_clr);
  end

  // State, captured op, WB fields and sticky errors.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      op_q           <= '0;
      wb_q           <= '0;
      misalign_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      wb_q           <= wb_d;
      misalign_err_q <= misalign_err_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  // Memory port is driven only from the captured op while in ACCESS.
  assign dm_req   = (state_q == ACCESS);
  assign dm_we    = dm_req && op_q.we;
  assign dm_addr  = dm_req ? op_q.addr  : '0;
  assign dm_be    = dm_req ? op_q.be    : 4'b0000;
  assign dm_wdata = dm_req ? op_q.wdata : '0;

  // NOTE: the stall is partly combinational from the EX/MEM inputs, so it is
  // masked by reset directly to drop at once rather than at the next edge.
  assign mem_stall = stall_c && !reset;

  assign wb_valid     = wb_q.valid;
  assign wb_regwrite  = wb_q.regwrite;
  assign wb_memtoreg  = wb_q.memtoreg;
  assign wb_rd        = wb_q.rd;
  assign wb_aluresult = wb_q.aluresult;
  assign wb_pcplus4   = wb_q.pcplus4;
  assign wb_readdata  = wb_q.readdata;
  assign misalign_err = misalign_err_q;
  assign timeout_err  = timeout_err_q;

endmodule
